// File: rtl/cache_mem_bridge.sv
// Memory-side line transfer engine below the cache controller.
// Splits one write-back or refill into LINE_SIZE word transfers.
module cache_mem_bridge #(
  parameter int LINE_SIZE = 4,
  parameter int OFF_WIDTH = $clog2(LINE_SIZE)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [31:0]          req_addr_i,
  output logic [OFF_WIDTH-1:0] line_offset_o,
  input  logic [31:0]          wb_data_i,
  output logic                 fill_we_o,
  output logic [31:0]          fill_data_o,
  output logic                 done_o,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WRITE     = 3'd1;
  localparam logic [2:0] READ_REQ  = 3'd2;
  localparam logic [2:0] READ_WAIT = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  logic [2:0]           state_q;
  logic [OFF_WIDTH-1:0] cnt_q;
  logic [31:OFF_WIDTH+2] base_q;
  logic                 wr_q;
  logic                 last;

  assign last = (cnt_q == OFF_WIDTH'(LINE_SIZE - 1));

  always_comb begin
    req_ready_o   = 1'b0;
    line_offset_o = cnt_q;
    fill_we_o     = 1'b0;
    fill_data_o   = 32'h0;
    done_o        = 1'b0;
    mem_valid_o   = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = 32'h0;
    mem_wdata_o   = 32'h0;
    case (state_q)
      IDLE: req_ready_o = 1'b1;
      WRITE: begin
        mem_valid_o = 1'b1;
        mem_write_o = wr_q;
        mem_addr_o  = {base_q, cnt_q, 2'b00};
        mem_wdata_o = wb_data_i;
      end
      READ_REQ: begin
        mem_valid_o = 1'b1;
        mem_addr_o  = {base_q, cnt_q, 2'b00};
      end
      READ_WAIT: begin
        fill_we_o   = mem_rvalid_i;
        fill_data_o = mem_rvalid_i ? mem_rdata_i : 32'h0;
      end
      DONE: done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            base_q  <= req_addr_i[31:OFF_WIDTH+2];
            wr_q    <= req_write_i;
            cnt_q   <= '0;
            state_q <= req_write_i ? WRITE : READ_REQ;
          end
        end
        WRITE: begin
          if (mem_ready_i) begin
            if (last) state_q <= DONE;
            else      cnt_q   <= cnt_q + 1'b1;
          end
        end
        READ_REQ: begin
          if (mem_ready_i) state_q <= READ_WAIT;
        end
        READ_WAIT: begin
          if (mem_rvalid_i) begin
            if (last) begin
              state_q <= DONE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= READ_REQ;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Scoreboard bench for cache_mem_bridge with a small memory responder.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_cache_mem_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [1:0]  line_offset_o;
  logic [31:0] wb_data_i;
  logic        fill_we_o;
  logic [31:0] fill_data_o;
  logic        done_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  cache_mem_bridge #(.LINE_SIZE(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .line_offset_o(line_offset_o), .wb_data_i(wb_data_i),
    .fill_we_o(fill_we_o), .fill_data_o(fill_data_o),
    .done_o(done_o), .mem_valid_o(mem_valid_o),
    .mem_ready_i(mem_ready_i), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } mem_exp_t;

  typedef struct {
    logic [1:0]  off;
    logic [31:0] data;
    int          rel;
  } fill_exp_t;

  mem_exp_t  exp_mem[$];
  fill_exp_t exp_fill[$];
  int        exp_done[$];
  logic [31:0] resp_q[$];

  logic [31:0] wb_line [4];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int lat = 1;
  int wait_cnt = 0;

  assign wb_data_i = wb_line[line_offset_o];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Read responder: answers an accepted read lat cycles later
  always @(negedge clk_i) begin
    if (rst_ni && mem_valid_o && mem_ready_i && !mem_write_o)
      wait_cnt = lat;
  end

  always @(posedge clk_i) begin
    #1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    if (!rst_ni) begin
      wait_cnt = 0;
    end else if (wait_cnt > 0) begin
      wait_cnt--;
      if (wait_cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = (resp_q.size() > 0) ? resp_q.pop_front()
                                           : 32'hBAD0BAD0;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk_i) begin
    mem_exp_t  m;
    fill_exp_t f;
    int        r;
    if (rst_ni) begin
      if (mem_valid_o && mem_ready_i) begin
        if (exp_mem.size() == 0) begin
          chk("mem_unexpected", mem_addr_o, 32'hFFFFFFFF);
        end else begin
          m = exp_mem.pop_front();
          chk("mem_addr", mem_addr_o, m.addr);
          chk("mem_write", {31'b0, mem_write_o}, {31'b0, m.wr});
          if (m.wr) chk("mem_wdata", mem_wdata_o, m.data);
        end
      end
      if (fill_we_o) begin
        if (exp_fill.size() == 0) begin
          chk("fill_unexpected", fill_data_o, 32'hFFFFFFFF);
        end else begin
          f = exp_fill.pop_front();
          chk("fill_off", {30'b0, line_offset_o}, {30'b0, f.off});
          chk("fill_data", fill_data_o, f.data);
          if (f.rel >= 0)
            chk("fill_cycle", cyc - acc_cyc, f.rel);
        end
      end
      if (done_o) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          r = exp_done.pop_front();
          if (r >= 0) chk("done_cycle", cyc - acc_cyc, r);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic push_read(input logic [31:0] a, input logic [31:0] d0,
                           input bit timed);
    logic [31:0] b;
    b = a & 32'hFFFFFFF0;
    for (int i = 0; i < 4; i++) begin
      exp_mem.push_back('{b + 32'(i * 4), 1'b0, 32'h0});
      resp_q.push_back(d0 + 32'(i));
      exp_fill.push_back('{2'(i), d0 + 32'(i), timed ? 2 + 2 * i : -1});
    end
    exp_done.push_back(timed ? 9 : -1);
  endtask

  task automatic push_write(input logic [31:0] a, input int rel);
    logic [31:0] b;
    b = a & 32'hFFFFFFF0;
    for (int i = 0; i < 4; i++)
      exp_mem.push_back('{b + 32'(i * 4), 1'b1, wb_line[i]});
    exp_done.push_back(rel);
  endtask

  task automatic issue(input logic [31:0] a, input logic w);
    int n;
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_write_i = w;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(req_ready_o && rst_ni) && n < 200);
    if (n >= 200) chk("accept_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!done_o && n < 300);
    if (n >= 300) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rd(input logic [1:0] off);
    int n;
    n = 0;
    while (!(mem_valid_o && !mem_write_o && line_offset_o == off)
           && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("read_req_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_ni       = 1'b0;
    req_valid_i  = 1'b0;
    req_write_i  = 1'b0;
    req_addr_i   = 32'h0;
    mem_ready_i  = 1'b1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    for (int i = 0; i < 4; i++) wb_line[i] = 32'hB0 + 32'(i);

    repeat (2) @(negedge clk_i);
    chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_mem_valid", {31'b0, mem_valid_o}, 32'd0);
    chk("rst_fill_we", {31'b0, fill_we_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_offset", {30'b0, line_offset_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Refill with exact cycle timing
    push_read(32'h0000_1237, 32'hA0, 1'b1);
    issue(32'h0000_1237, 1'b0);
    wait_done();
    @(negedge clk_i);
    chk("ready_after_done", {31'b0, req_ready_o}, 32'd1);
    tick();

    // Write-back with ready low for two cycles on word 1
    push_write(32'h8000_0040, 7);
    issue(32'h8000_0040, 1'b1);
    n = 0;
    while (!(mem_valid_o && mem_write_o && line_offset_o == 2'd1)
           && n < 50) begin
      tick();
      n++;
    end
    mem_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("stall_addr", mem_addr_o, 32'h8000_0044);
      chk("stall_wdata", mem_wdata_o, 32'hB1);
      tick();
      if (k == 1) mem_ready_i = 1'b1;
    end
    wait_done();
    tick();

    // Stray rvalid in IDLE and READ_REQ
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_0001;
    @(negedge clk_i);
    chk("stray_idle_fill", {31'b0, fill_we_o}, 32'd0);
    tick();
    push_read(32'h0000_2000, 32'hC0, 1'b0);
    issue(32'h0000_2000, 1'b0);
    wait_rd(2'd1);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_0002;
    @(negedge clk_i);
    chk("stray_rreq_fill", {31'b0, fill_we_o}, 32'd0);
    chk("stray_rreq_off", {30'b0, line_offset_o}, 32'd1);
    wait_done();
    tick();

    // req_valid held through a refill
    push_read(32'h0000_3000, 32'hD0, 1'b0);
    push_read(32'h0000_3000, 32'hD0, 1'b0);
    req_addr_i  = 32'h0000_3000;
    req_write_i = 1'b0;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    chk("held_first_accept", {31'b0, req_ready_o}, 32'd1);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
      chk("held_busy_ready", {31'b0, req_ready_o}, 32'd0);
    end while (!done_o && n < 100);
    @(negedge clk_i);
    chk("held_second_accept", {31'b0, req_ready_o}, 32'd1);
    tick();
    req_valid_i = 1'b0;
    wait_done();
    tick();

    // Reset in the middle of a refill
    exp_mem.push_back('{32'h0000_5000, 1'b0, 32'h0});
    exp_mem.push_back('{32'h0000_5004, 1'b0, 32'h0});
    resp_q.push_back(32'hE0);
    resp_q.push_back(32'hE1);
    exp_fill.push_back('{2'd0, 32'hE0, -1});
    exp_fill.push_back('{2'd1, 32'hE1, -1});
    issue(32'h0000_5000, 1'b0);
    wait_rd(2'd2);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, mem_valid_o}, 32'd0);
    chk("mid_rst_offset", {30'b0, line_offset_o}, 32'd0);
    chk("mid_rst_done", {31'b0, done_o}, 32'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    chk("mid_rst_mem_q", exp_mem.size(), 32'd0);
    chk("mid_rst_fill_q", exp_fill.size(), 32'd0);
    tick();
    push_read(32'h0000_5000, 32'hF0, 1'b0);
    issue(32'h0000_5000, 1'b0);
    wait_done();
    tick();

    // Eviction: write-back then refill back to back
    for (int i = 0; i < 4; i++) wb_line[i] = 32'h5500 + 32'(i);
    push_write(32'h6000_0100, -1);
    lat = 3;
    push_read(32'h7000_0100, 32'h70, 1'b0);
    issue(32'h6000_0100, 1'b1);
    issue(32'h7000_0100, 1'b0);
    wait_done();
    tick();

    repeat (4) tick();
    chk("end_mem_q", exp_mem.size(), 32'd0);
    chk("end_fill_q", exp_fill.size(), 32'd0);
    chk("end_done_q", exp_done.size(), 32'd0);
    chk("end_resp_q", resp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
